// File: rtl/disp7_pkg.sv
// disp7_pkg: segment patterns, slot indices and conversion states shared by the
// 7-segment bus decoder.
package disp7_pkg;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int UNI = 0;
    localparam int DEC = 1;
    localparam int CEN = 2;
    localparam int MIL = 3;
    typedef enum logic [2:0] {IDLE, MUL3, MUL2, MUL1, DONE} conv_e;
endpackage

// File: rtl/decodificador_7_segmentos_if.sv
// decodificador_7_segmentos_if: multiplexed display bus plus decoded results.
interface decodificador_7_segmentos_if;
    logic [3:0]  selec_digito;
    logic [7:0]  numero_cod;
    logic [15:0] bcd;
    logic [13:0] valor;
    logic        valido;
    logic        error_patron;
    logic        sin_senal;
    logic [3:0]  punto;
    modport master (output selec_digito, numero_cod, input bcd, valor, valido, error_patron, sin_senal, punto);
    modport slave  (input selec_digito, numero_cod, output bcd, valor, valido, error_patron, sin_senal, punto);
endinterface

// File: rtl/seg7_a_bcd.sv
// seg7_a_bcd: active-low segment pattern (dp already stripped) to BCD digit lookup.
module seg7_a_bcd
    import disp7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       ilegal,
    output logic [3:0] digito
);
    logic [7:0] p;
    assign p = {1'b1, seg};
    always_comb begin
        ilegal = 1'b0;
        digito = 4'd0;
        case (p)
            SEG_0, SEG_BLANK: digito = 4'd0;
            SEG_1: digito = 4'd1;
            SEG_2: digito = 4'd2;
            SEG_3: digito = 4'd3;
            SEG_4: digito = 4'd4;
            SEG_5: digito = 4'd5;
            SEG_6: digito = 4'd6;
            SEG_7: digito = 4'd7;
            SEG_8: digito = 4'd8;
            SEG_9: digito = 4'd9;
            default: ilegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/decodificador_7_segmentos.sv
// decodificador_7_segmentos: rebuilds the 4-digit value from a scanned 7-segment bus.
// Define DECIMAL_POINT_EN to capture decimal points into punto.
module decodificador_7_segmentos
    import disp7_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input logic clock,
    input logic reset_n,
    decodificador_7_segmentos_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [3:0] sel_m, sel, sel_p, kb, mask, digito, sumando;
    logic [7:0] cod_m, cod, cod_p;
    logic [SW-1:0] stab;
    logic [TW-1:0] to_cnt;
    logic [3:0][3:0] slot, pend, conv;
    logic [13:0] acc, valor_r;
    logic [15:0] bcd_r;
    logic [1:0] k;
    logic cand, igual, acepta, ilegal, bad, completo, ok, limpia, to_hit;
    logic pend_v, guarda, arranca, usa_pend, paso, fin, valido_r, error_r, sin_r;
    conv_e estado, sig;

    seg7_a_bcd u_lut (.seg(cod[6:0]), .ilegal(ilegal), .digito(digito));

    assign cand     = $onehot(~sel);
    assign igual    = (sel == sel_p) && (cod == cod_p);
    assign acepta   = cand && igual && (stab == SW'(STABLE_CYC - 1));
    assign kb       = acepta ? ~sel : 4'h0;
    assign k        = !sel[UNI] ? 2'd0 : !sel[DEC] ? 2'd1 : !sel[CEN] ? 2'd2 : 2'd3;
    assign completo = mask == 4'hF;
    assign ok       = completo && !bad;
    assign to_hit   = to_cnt == TW'(TIMEOUT_CYC);
    assign limpia   = completo || to_hit;
    // a good frame is parked when the converter is busy or already has one queued ahead
    assign guarda   = ok && (estado != IDLE || pend_v);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_m <= 4'hF;
            sel   <= 4'hF;
            sel_p <= 4'hF;
            cod_m <= 8'hFF;
            cod   <= 8'hFF;
            cod_p <= 8'hFF;
            stab  <= '0;
        end else begin
            sel_m <= bus.selec_digito;
            sel   <= sel_m;
            cod_m <= bus.numero_cod;
            cod   <= cod_m;
            sel_p <= sel;
            cod_p <= cod;
            stab  <= !cand ? '0 : !igual ? SW'(1) : (stab == SW'(STABLE_CYC)) ? stab : stab + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot    <= '0;
            mask    <= '0;
            bad     <= 1'b0;
            error_r <= 1'b0;
            to_cnt  <= '0;
            sin_r   <= 1'b0;
        end else begin
            if (acepta) slot[k] <= digito;
            mask    <= (limpia ? 4'h0 : mask) | kb;
            bad     <= (!limpia && bad) || (acepta && ilegal);
            error_r <= completo && bad;
            to_cnt  <= acepta ? '0 : to_hit ? to_cnt : to_cnt + 1'b1;
            sin_r   <= !acepta && (to_hit || sin_r);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            pend_v   <= 1'b0;
            conv     <= '0;
            acc      <= '0;
            bcd_r    <= '0;
            valor_r  <= '0;
            valido_r <= 1'b0;
        end else begin
            if (guarda) pend <= slot;
            pend_v <= guarda || (pend_v && !usa_pend);
            if (arranca) conv <= usa_pend ? pend : slot;
            acc <= arranca ? {10'd0, usa_pend ? pend[MIL] : slot[MIL]}
                 : paso ? (acc << 3) + (acc << 1) + {10'd0, sumando} : acc;
            if (fin) begin
                bcd_r   <= conv;
                valor_r <= acc;
            end
            valido_r <= fin;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= IDLE;
        else estado <= sig;
    end

    always_comb begin
        sig = IDLE;
        case (estado)
            IDLE:    sig = arranca ? MUL3 : IDLE;
            MUL3:    sig = MUL2;
            MUL2:    sig = MUL1;
            MUL1:    sig = DONE;
            default: sig = IDLE;
        endcase
    end

    always_comb begin
        usa_pend = (estado == IDLE) && pend_v;
        arranca  = (estado == IDLE) && (pend_v || ok);
        paso     = estado inside {MUL3, MUL2, MUL1};
        fin      = estado == DONE;
        sumando  = estado == MUL3 ? conv[CEN] : estado == MUL2 ? conv[DEC] : conv[UNI];
    end

    assign bus.bcd          = bcd_r;
    assign bus.valor        = valor_r;
    assign bus.valido       = valido_r;
    assign bus.error_patron = error_r;
    assign bus.sin_senal    = sin_r;

`ifdef DECIMAL_POINT_EN
    logic [3:0] dp_slot, dp_pend, dp_conv, punto_r;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dp_slot <= '0;
            dp_pend <= '0;
            dp_conv <= '0;
            punto_r <= '0;
        end else begin
            dp_slot <= ((limpia ? 4'h0 : dp_slot) & ~kb) | (cod[7] ? 4'h0 : kb);
            if (guarda) dp_pend <= dp_slot;
            if (arranca) dp_conv <= usa_pend ? dp_pend : dp_slot;
            if (fin) punto_r <= dp_conv;
        end
    end
    assign bus.punto = punto_r;
`else
    assign bus.punto = 4'h0;
`endif
endmodule

// File: tb/tb_decodificador_7_segmentos.sv
// tb_decodificador_7_segmentos: randomized frames against a digit-table model, scoreboard-checked.
module tb_decodificador_7_segmentos;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 64;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    decodificador_7_segmentos_if b();
    decodificador_7_segmentos #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clock(clock), .reset_n(reset_n), .bus(b));
    always #5 clock = ~clock;

    typedef struct {
        bit          err;
        int          valor;
        logic [15:0] bcd;
        logic [3:0]  punto;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int total = 0;
    int passed = 0;
    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    function automatic int dec(input logic [7:0] p);
        logic [7:0] m;
        m = p | 8'h80;
        if (m == 8'hFF) return 0;
        for (int i = 0; i < 10; i++) if (m == tbl[i]) return i;
        return -1;
    endfunction

    function automatic exp_t model(input logic [3:0][7:0] p);
        exp_t e;
        int d;
        e.err = 0; e.valor = 0; e.bcd = '0; e.punto = '0;
        for (int k = 0; k < 4; k++) begin
            d = dec(p[k]);
            if (d < 0) e.err = 1;
            else begin
                e.valor += d * (10 ** k);
                e.bcd[4*k +: 4] = 4'(d);
            end
`ifdef DECIMAL_POINT_EN
            e.punto[k] = !p[k][7];
`endif
        end
        return e;
    endfunction

    task automatic drive_slot(input int k, input logic [7:0] p, input int n);
        @(negedge clock);
        b.selec_digito = 4'(~(4'b0001 << k));
        b.numero_cod = p;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            b.selec_digito = 4'hF;
        end
    endtask

    // short_k >= 0 dwells below threshold on that slot, so no response is expected
    task automatic frame(input logic [3:0][7:0] p, input int short_k, input bit chk_sin);
        if (short_k < 0) q.push_back(model(p));
        for (int k = 0; k < 4; k++) begin
            drive_slot(k, p[k], k == short_k ? 3 : (chk_sin && k == 0) ? 8 : int'($urandom_range(4, 7)));
            if (chk_sin && k == 0) chk("sin_senal_clear", b.sin_senal, 0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(12);
    endtask

    function automatic logic [3:0][7:0] rand_frame();
        logic [3:0][7:0] p;
        logic [7:0] r;
        int s;
        for (int k = 0; k < 4; k++) begin
            s = int'($urandom_range(0, 23));
            if (s < 20) p[k] = tbl[s % 10];
            else if (s < 23) p[k] = 8'hFF;
            else begin
                do r = 8'($urandom); while (dec(r) >= 0);
                p[k] = r;
            end
            if ($urandom_range(0, 3) == 0) p[k][7] = 1'b0;
        end
        return p;
    endfunction

    always @(posedge clock) begin
        #1;
        if (reset_n && (b.valido || b.error_patron)) begin
            if (q.size() == 0) chk("unexpected_output", {b.valido, b.error_patron}, 0);
            else begin
                mon_e = q.pop_front();
                chk("kind_error", b.error_patron, mon_e.err);
                chk("kind_valido", b.valido, !mon_e.err);
                if (!mon_e.err) begin
                    chk("valor", b.valor, mon_e.valor);
                    chk("bcd", b.bcd, mon_e.bcd);
                    chk("punto", b.punto, mon_e.punto);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        b.selec_digito = 4'hF;
        b.numero_cod = 8'hFF;
        repeat (3) @(negedge clock);
        chk("rst_bcd", b.bcd, 0);
        chk("rst_valor", b.valor, 0);
        chk("rst_valido", b.valido, 0);
        chk("rst_error", b.error_patron, 0);
        chk("rst_sin_senal", b.sin_senal, 0);
        chk("rst_punto", b.punto, 0);
        reset_n = 1'b1;
        frame({8'hF9, 8'hA4, 8'h99, 8'hC0}, -1, 0);
        chk("t1_bcd", b.bcd, 16'h1240);
        chk("t1_sin_senal", b.sin_senal, 0);
        frame({8'hF9, 8'hAA, 8'h99, 8'hC0}, -1, 0);
        chk("t2_bcd_held", b.bcd, 16'h1240);
        frame({8'hFF, 8'hFF, 8'h90, 8'hF8}, -1, 0);
        chk("t5_valor", b.valor, 97);
        frame({8'hC0, 8'hC0, 8'h10, 8'hC0}, -1, 0);
`ifdef DECIMAL_POINT_EN
        chk("t6_punto", b.punto, 4'b0010);
`else
        chk("t6_punto", b.punto, 4'b0000);
`endif
        for (int i = 0; i < 25; i++) frame(rand_frame(), -1, 0);
        frame({8'hF9, 8'hC0, 8'hC0, 8'hC0}, 2, 0);
        idle(TIMEOUT_CYC + 10);
        chk("t4_sin_senal_set", b.sin_senal, 1);
        frame({8'h90, 8'h90, 8'h90, 8'h90}, -1, 1);
        chk("t4_valor", b.valor, 9999);
        for (int k = 0; k < 3; k++) drive_slot(k, tbl[k + 5], 5);
        drive_slot(3, 8'h80, 8);
        reset_n = 1'b0;
        b.selec_digito = 4'hF;
        #1;
        chk("abort_valor", b.valor, 0);
        chk("abort_bcd", b.bcd, 0);
        chk("abort_valido", b.valido, 0);
        chk("abort_sin_senal", b.sin_senal, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        idle(20);
        frame(rand_frame(), -1, 0);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clock);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
